// File: rtl/nvdla_dbb_rd_arbiter_pkg.sv
// Shared types and helpers for the DBB read-request arbiter.
package nvdla_dbb_rd_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } state_arb_fsm_t;

  localparam int NVDLA_DBB_MAX_CH = 16;

  // Channel-index width; a 2-channel arbiter still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nvdla_rr_arbiter.sv
// Combinational round-robin search starting at ptr; yields one-hot and encoded grant.
module nvdla_rr_arbiter
  import nvdla_dbb_rd_arbiter_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [CH_W-1:0] ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_valid
);

  logic [CH_W:0]   sum;
  logic [CH_W-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        sum = {1'b0, ptr} + (CH_W+1)'(i);
        if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
        idx = sum[CH_W-1:0];
        if (!gnt_valid && eligible[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx;
          gnt[idx]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nvdla_dbb_rd_arbiter.sv
// N-channel DBB read arbiter: round-robin request merge, ID tagging, read-data routing.
// Optional per-channel stall counters enabled by NVDLA_DBB_ARB_PERF_EN.
module nvdla_dbb_rd_arbiter
  import nvdla_dbb_rd_arbiter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 4,
  parameter int ID_W      = 8,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 8,
  localparam int CH_W     = clog2_min1(N_CH),
  localparam int LID_W    = ID_W - CH_W,
  localparam int OUT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          ch_req_valid_i,
  output logic [N_CH-1:0]          ch_req_ready_o,
  input  logic [N_CH*ADDR_W-1:0]   ch_req_addr_i,
  input  logic [N_CH*LEN_W-1:0]    ch_req_len_i,
  input  logic [N_CH*LID_W-1:0]    ch_req_id_i,
  output logic [N_CH-1:0]          ch_rdat_valid_o,
  input  logic [N_CH-1:0]          ch_rdat_ready_i,
  output logic [DATA_W-1:0]        ch_rdat_data_o,
  output logic                     ch_rdat_last_o,
  output logic [LID_W-1:0]         ch_rdat_id_o,
  output logic                     mst_req_valid_o,
  input  logic                     mst_req_ready_i,
  output logic [ADDR_W-1:0]        mst_req_addr_o,
  output logic [LEN_W-1:0]         mst_req_len_o,
  output logic [ID_W-1:0]          mst_req_id_o,
  input  logic                     mst_rdat_valid_i,
  output logic                     mst_rdat_ready_o,
  input  logic [DATA_W-1:0]        mst_rdat_data_i,
  input  logic                     mst_rdat_last_i,
  input  logic [ID_W-1:0]          mst_rdat_id_i,
  output logic                     idle_o,
  output logic                     err_o,
  output logic [N_CH*32-1:0]       stall_cnt_o
);

  if (N_CH < 2 || N_CH > NVDLA_DBB_MAX_CH) begin : g_bad_n_ch
    $error("nvdla_dbb_rd_arbiter: N_CH out of range");
  end

  state_arb_fsm_t    state;
  logic [CH_W-1:0]   rr_ptr;
  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              load_en;
  logic              req_hs;
  logic              rd_last_hs;
  logic              rd_ch_ok;
  logic [CH_W-1:0]   mst_ch;
  logic [CH_W-1:0]   rd_ch;
  logic [N_CH-1:0]   outst_nz;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [LID_W-1:0]  sel_lid;

  assign load_en        = (state == ARB_IDLE) || mst_req_ready_i;
  assign req_hs         = mst_req_valid_o && mst_req_ready_i;
  assign mst_ch         = mst_req_id_o[ID_W-1 -: CH_W];
  assign rd_ch          = mst_rdat_id_i[ID_W-1 -: CH_W];
  assign ch_req_ready_o = gnt;

  nvdla_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .en        (load_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_lid  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) begin
        sel_addr = ch_req_addr_i[c*ADDR_W +: ADDR_W];
        sel_len  = ch_req_len_i[c*LEN_W +: LEN_W];
        sel_lid  = ch_req_id_i[c*LID_W +: LID_W];
      end
    end
  end

  // Output register: loads on a grant whenever empty or being drained this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= ARB_IDLE;
      mst_req_valid_o <= 1'b0;
      mst_req_addr_o  <= '0;
      mst_req_len_o   <= '0;
      mst_req_id_o    <= '0;
      rr_ptr          <= '0;
    end else if (load_en) begin
      if (gnt_valid) begin
        state           <= ARB_HOLD;
        mst_req_valid_o <= 1'b1;
        mst_req_addr_o  <= sel_addr;
        mst_req_len_o   <= sel_len;
        mst_req_id_o    <= {gnt_idx, sel_lid};
        rr_ptr          <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        state           <= ARB_IDLE;
        mst_req_valid_o <= 1'b0;
      end
    end
  end

  if (N_CH == (1 << CH_W)) begin : g_ch_pow2
    assign rd_ch_ok = 1'b1;
  end else begin : g_ch_npow2
    assign rd_ch_ok = ({1'b0, rd_ch} < (CH_W+1)'(N_CH));
  end

  always_comb begin
    ch_rdat_valid_o  = '0;
    mst_rdat_ready_o = 1'b1;
    if (rd_ch_ok) begin
      ch_rdat_valid_o[rd_ch] = mst_rdat_valid_i;
      mst_rdat_ready_o       = ch_rdat_ready_i[rd_ch];
    end
  end

  assign ch_rdat_data_o = mst_rdat_data_i;
  assign ch_rdat_last_o = mst_rdat_last_i;
  assign ch_rdat_id_o   = mst_rdat_id_i[LID_W-1:0];
  assign rd_last_hs     = mst_rdat_valid_i && mst_rdat_ready_o && mst_rdat_last_i && rd_ch_ok;

  for (genvar c = 0; c < N_CH; c++) begin : g_outst
    logic [OUT_W-1:0] cnt;
    logic             inc;
    logic             dec;
    logic             pend;

    assign inc  = req_hs && (mst_ch == CH_W'(c));
    assign dec  = rd_last_hs && (rd_ch == CH_W'(c)) && (cnt != '0);
    assign pend = mst_req_valid_o && (mst_ch == CH_W'(c));
    // A request parked in the output register already owns a slot.
    assign eligible[c] = ch_req_valid_i[c] &&
                         (({1'b0, cnt} + (OUT_W+1)'(pend)) < (OUT_W+1)'(MAX_OUTST));
    assign outst_nz[c] = |cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_o <= 1'b1;
      err_o  <= 1'b0;
    end else begin
      idle_o <= (state == ARB_IDLE) && (outst_nz == '0);
      if (mst_rdat_valid_i && !rd_ch_ok) err_o <= 1'b1;
    end
  end

`ifdef NVDLA_DBB_ARB_PERF_EN
  for (genvar c = 0; c < N_CH; c++) begin : g_stall
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_q <= '0;
      end else if (ch_req_valid_i[c] && !ch_req_ready_o[c] && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end

    assign stall_cnt_o[c*32 +: 32] = stall_q;
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_nvdla_dbb_rd_arbiter.sv
// Directed scoreboard bench for nvdla_dbb_rd_arbiter (4-channel and 3-channel builds).
module tb_nvdla_dbb_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 4;
  localparam int IW = 8;
  localparam int LIDW = 6;
  localparam int DW = 512;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IW-1:0] id;
  } req_t;

  typedef struct {
    logic [DW-1:0]   data;
    logic            last;
    logic [LIDW-1:0] lid;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      ch_req_valid;
  logic [N-1:0]      ch_req_ready;
  logic [N*AW-1:0]   ch_req_addr;
  logic [N*LW-1:0]   ch_req_len;
  logic [N*LIDW-1:0] ch_req_id;
  logic [N-1:0]      ch_rdat_valid;
  logic [N-1:0]      ch_rdat_ready;
  logic [DW-1:0]     ch_rdat_data;
  logic              ch_rdat_last;
  logic [LIDW-1:0]   ch_rdat_id;
  logic              mst_req_valid;
  logic              mst_req_ready;
  logic [AW-1:0]     mst_req_addr;
  logic [LW-1:0]     mst_req_len;
  logic [IW-1:0]     mst_req_id;
  logic              mst_rdat_valid;
  logic              mst_rdat_ready;
  logic [DW-1:0]     mst_rdat_data;
  logic              mst_rdat_last;
  logic [IW-1:0]     mst_rdat_id;
  logic              idle;
  logic              err;
  logic [N*32-1:0]   stall_cnt;

  logic [2:0]        d3_ch_req_ready;
  logic [2:0]        d3_ch_rdat_valid;
  logic [DW-1:0]     d3_ch_rdat_data;
  logic              d3_ch_rdat_last;
  logic [5:0]        d3_ch_rdat_id;
  logic              d3_mst_req_valid;
  logic [AW-1:0]     d3_mst_req_addr;
  logic [LW-1:0]     d3_mst_req_len;
  logic [IW-1:0]     d3_mst_req_id;
  logic              d3_mst_rdat_ready;
  logic              d3_rdat_valid;
  logic [IW-1:0]     d3_rdat_id;
  logic              d3_idle;
  logic              d3_err;
  logic [3*32-1:0]   d3_stall_cnt;

  int passCount  = 0;
  int checkCount = 0;
  req_t  reqQ[$];
  beat_t beatQ[$];

  always #5 clk = ~clk;

  nvdla_dbb_rd_arbiter dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ch_req_valid_i   (ch_req_valid),
    .ch_req_ready_o   (ch_req_ready),
    .ch_req_addr_i    (ch_req_addr),
    .ch_req_len_i     (ch_req_len),
    .ch_req_id_i      (ch_req_id),
    .ch_rdat_valid_o  (ch_rdat_valid),
    .ch_rdat_ready_i  (ch_rdat_ready),
    .ch_rdat_data_o   (ch_rdat_data),
    .ch_rdat_last_o   (ch_rdat_last),
    .ch_rdat_id_o     (ch_rdat_id),
    .mst_req_valid_o  (mst_req_valid),
    .mst_req_ready_i  (mst_req_ready),
    .mst_req_addr_o   (mst_req_addr),
    .mst_req_len_o    (mst_req_len),
    .mst_req_id_o     (mst_req_id),
    .mst_rdat_valid_i (mst_rdat_valid),
    .mst_rdat_ready_o (mst_rdat_ready),
    .mst_rdat_data_i  (mst_rdat_data),
    .mst_rdat_last_i  (mst_rdat_last),
    .mst_rdat_id_i    (mst_rdat_id),
    .idle_o           (idle),
    .err_o            (err),
    .stall_cnt_o      (stall_cnt)
  );

  nvdla_dbb_rd_arbiter #(.N_CH(3)) dut3 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ch_req_valid_i   (3'b000),
    .ch_req_ready_o   (d3_ch_req_ready),
    .ch_req_addr_i    ('0),
    .ch_req_len_i     ('0),
    .ch_req_id_i      ('0),
    .ch_rdat_valid_o  (d3_ch_rdat_valid),
    .ch_rdat_ready_i  (3'b000),
    .ch_rdat_data_o   (d3_ch_rdat_data),
    .ch_rdat_last_o   (d3_ch_rdat_last),
    .ch_rdat_id_o     (d3_ch_rdat_id),
    .mst_req_valid_o  (d3_mst_req_valid),
    .mst_req_ready_i  (1'b1),
    .mst_req_addr_o   (d3_mst_req_addr),
    .mst_req_len_o    (d3_mst_req_len),
    .mst_req_id_o     (d3_mst_req_id),
    .mst_rdat_valid_i (d3_rdat_valid),
    .mst_rdat_ready_o (d3_mst_rdat_ready),
    .mst_rdat_data_i  ('0),
    .mst_rdat_last_i  (1'b1),
    .mst_rdat_id_i    (d3_rdat_id),
    .idle_o           (d3_idle),
    .err_o            (d3_err),
    .stall_cnt_o      (d3_stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setChannel(input int c, input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input logic [LIDW-1:0] i);
    ch_req_addr[c*AW +: AW]   = a;
    ch_req_len[c*LW +: LW]    = l;
    ch_req_id[c*LIDW +: LIDW] = i;
  endtask

  task automatic applyReset();
    rst_n          = 1'b0;
    ch_req_valid   = '0;
    ch_req_addr    = '0;
    ch_req_len     = '0;
    ch_req_id      = '0;
    ch_rdat_ready  = '0;
    mst_req_ready  = 1'b0;
    mst_rdat_valid = 1'b0;
    mst_rdat_data  = '0;
    mst_rdat_last  = 1'b0;
    mst_rdat_id    = '0;
    d3_rdat_valid  = 1'b0;
    d3_rdat_id     = '0;
    repeat (2) stepCycle();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: pops expectations whenever a handshake is visible.
  always @(negedge clk) begin : monitor
    req_t  er;
    beat_t eb;
    if (rst_n) begin
      if (mst_req_valid && mst_req_ready) begin
        if (reqQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL mst_req_unexpected: got id 0x%0h addr 0x%0h required none",
                   mst_req_id, mst_req_addr);
        end else begin
          er = reqQ.pop_front();
          checkOutput("mst_req", {84'd0, mst_req_addr, mst_req_len, mst_req_id},
                      {84'd0, er.addr, er.len, er.id});
        end
      end
      if (mst_rdat_valid && mst_rdat_ready) begin
        checkCount++;
        if (beatQ.size() == 0) begin
          $display("[TB] FAIL rdat_unexpected: got data 0x%0h required none", ch_rdat_data[63:0]);
        end else begin
          eb = beatQ.pop_front();
          if (ch_rdat_data === eb.data && ch_rdat_last === eb.last && ch_rdat_id === eb.lid)
            passCount++;
          else
            $display("[TB] FAIL rdat_beat: got data 0x%0h last %0b id 0x%0h expected 0x%0h %0b 0x%0h",
                     ch_rdat_data[63:0], ch_rdat_last, ch_rdat_id, eb.data[63:0], eb.last, eb.lid);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [127:0] expStall;
    logic [5:0]   pat;
    int           beat;
    int           ch;

    applyReset();
    @(negedge clk);
    checkOutput("reset_valid", {127'd0, mst_req_valid}, 128'd0);
    checkOutput("reset_fields", {84'd0, mst_req_addr, mst_req_len, mst_req_id}, 128'd0);
    checkOutput("reset_idle", {127'd0, idle}, 128'd1);
    checkOutput("reset_err", {127'd0, err}, 128'd0);
    checkOutput("reset_stall", stall_cnt, 128'd0);
    stepCycle();

    // Round robin with all four channels requesting for ten cycles.
    applyReset();
    for (int c = 0; c < N; c++) setChannel(c, AW'(32'h100 * (c + 1)), LW'(c), '0);
    ch_req_valid  = 4'hF;
    mst_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ch = k % 4;
      reqQ.push_back('{addr: AW'(32'h100 * (ch + 1)), len: LW'(ch), id: IW'(ch << 6)});
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("rr_grant", {124'd0, ch_req_ready}, 128'(4'b0001 << (k % 4)));
      stepCycle();
    end
    ch_req_valid = '0;
    repeat (3) stepCycle();
`ifdef NVDLA_DBB_ARB_PERF_EN
    expStall = {32'd8, 32'd8, 32'd7, 32'd7};
`else
    expStall = '0;
`endif
    @(negedge clk);
    checkOutput("stall_cnt", stall_cnt, expStall);
    checkOutput("busy_idle", {127'd0, idle}, 128'd0);
    stepCycle();

    // Backpressure on the DBB side keeps the register stable.
    applyReset();
    setChannel(1, 32'h1000, 4'd3, 6'd5);
    ch_req_valid  = 4'b0010;
    mst_req_ready = 1'b0;
    reqQ.push_back('{addr: 32'h1000, len: 4'd3, id: 8'h45});
    reqQ.push_back('{addr: 32'h1000, len: 4'd3, id: 8'h45});
    @(negedge clk);
    checkOutput("hold_first_grant", {124'd0, ch_req_ready}, 128'h2);
    stepCycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("hold_stable", {83'd0, mst_req_valid, mst_req_addr, mst_req_len, mst_req_id},
                  {83'd0, 1'b1, 32'h1000, 4'd3, 8'h45});
      checkOutput("hold_no_ready", {124'd0, ch_req_ready}, 128'd0);
      stepCycle();
    end
    mst_req_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_regrant", {124'd0, ch_req_ready}, 128'h2);
    stepCycle();
    ch_req_valid = '0;
    repeat (3) stepCycle();
    @(negedge clk);
    checkOutput("hold_drained", {127'd0, mst_req_valid}, 128'd0);
    stepCycle();

    // Outstanding limit on channel 2.
    applyReset();
    setChannel(2, 32'h2000, 4'd0, 6'd3);
    ch_req_valid  = 4'b0100;
    mst_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) reqQ.push_back('{addr: 32'h2000, len: 4'd0, id: 8'h83});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("outst_grant", {124'd0, ch_req_ready}, 128'h4);
      stepCycle();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("outst_stall", {124'd0, ch_req_ready}, 128'd0);
      stepCycle();
    end
    mst_rdat_valid = 1'b1;
    mst_rdat_id    = 8'h83;
    mst_rdat_last  = 1'b1;
    mst_rdat_data  = DW'(512'h5A5A);
    ch_rdat_ready  = 4'b0100;
    beatQ.push_back('{data: DW'(512'h5A5A), last: 1'b1, lid: 6'd3});
    @(negedge clk);
    checkOutput("outst_rdat_valid", {124'd0, ch_rdat_valid}, 128'h4);
    stepCycle();
    mst_rdat_valid = 1'b0;
    reqQ.push_back('{addr: 32'h2000, len: 4'd0, id: 8'h83});
    @(negedge clk);
    checkOutput("outst_release", {124'd0, ch_req_ready}, 128'h4);
    stepCycle();
    ch_req_valid = '0;
    repeat (3) stepCycle();
    @(negedge clk);
    checkOutput("outst_not_idle", {127'd0, idle}, 128'd0);
    stepCycle();

    // Read data routing by ID with a toggling ready on channel 2.
    applyReset();
    pat  = 6'b101101;
    beat = 0;
    for (int k = 0; k < 4; k++)
      beatQ.push_back('{data: DW'(32'h1000 + k), last: (k == 3), lid: 6'd1});
    mst_rdat_valid = 1'b1;
    mst_rdat_id    = 8'h81;
    for (int cyc = 0; cyc < 6; cyc++) begin
      mst_rdat_data = DW'(32'h1000 + beat);
      mst_rdat_last = (beat == 3);
      ch_rdat_ready = {~pat[cyc], pat[cyc], ~pat[cyc], ~pat[cyc]};
      @(negedge clk);
      checkOutput("route_valid", {124'd0, ch_rdat_valid}, 128'h4);
      checkOutput("route_ready", {127'd0, mst_rdat_ready}, {127'd0, pat[cyc]});
      stepCycle();
      if (pat[cyc]) beat++;
    end
    mst_rdat_valid = 1'b0;
    ch_rdat_ready  = '0;
    @(negedge clk);
    checkOutput("route_idle", {127'd0, idle}, 128'd1);
    stepCycle();

    // Three-channel build: channel index 3 is invalid.
    applyReset();
    @(negedge clk);
    checkOutput("n3_err_reset", {127'd0, d3_err}, 128'd0);
    stepCycle();
    d3_rdat_valid = 1'b1;
    d3_rdat_id    = 8'hC0;
    @(negedge clk);
    checkOutput("n3_bad_ready", {127'd0, d3_mst_rdat_ready}, 128'd1);
    checkOutput("n3_bad_valid", {125'd0, d3_ch_rdat_valid}, 128'd0);
    stepCycle();
    d3_rdat_valid = 1'b0;
    @(negedge clk);
    checkOutput("n3_err_set", {127'd0, d3_err}, 128'd1);
    stepCycle();
    repeat (3) stepCycle();
    @(negedge clk);
    checkOutput("n3_err_sticky", {127'd0, d3_err}, 128'd1);
    checkOutput("n3_no_request", {124'd0, d3_mst_req_valid, d3_ch_req_ready}, 128'd0);
    checkOutput("main_err_clear", {127'd0, err}, 128'd0);
    stepCycle();

    checkOutput("req_queue_empty", 128'(reqQ.size()), 128'd0);
    checkOutput("beat_queue_empty", 128'(beatQ.size()), 128'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nvdla_dbb_rd_arbiter.md
Name: nvdla_dbb_rd_arbiter

Overview:
- N-channel read-path arbiter for the NVDLA primary memory interface (DBB).
- Merges per-channel read requests onto one DBB read-request port, using round-robin arbitration and a registered output.
- Tags each granted request's ID with its channel index, and routes returning read data back to the owning channel by ID.
- Generalises the fixed 8-bit-ID, 4-bit-length, single-channel DBB request structures with per-channel outstanding-transaction limits and an idle indication.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- ADDR_W, 32, request address width.
- LEN_W, 4, burst length field width (beats = len+1).
- ID_W, 8, DBB ID width; upper CH_W = clog2(N_CH) bits carry the channel index; lower ID_W-CH_W bits are the channel-local ID.
- DATA_W, 512, read data width.
- MAX_OUTST, 8, maximum outstanding bursts per channel (1..255).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, active-low.
- ch_req_valid_i  in  N_CH  per-channel request valid.
- ch_req_ready_o  out  N_CH  per-channel request ready.
- ch_req_addr_i  in  N_CH*ADDR_W  request address.
- ch_req_len_i  in  N_CH*LEN_W  burst length.
- ch_req_id_i  in  N_CH*(ID_W-CH_W)  channel-local ID.
- ch_rdat_valid_o  out  N_CH  routed read data valid.
- ch_rdat_ready_i  in  N_CH  channel read data ready.
- ch_rdat_data_o  out  DATA_W  read data, shared by all channels.
- ch_rdat_last_o  out  1  last beat, shared.
- ch_rdat_id_o  out  ID_W-CH_W  local ID, shared.
- mst_req_valid_o  out  1  DBB read request valid.
- mst_req_ready_i  in  1  DBB read request ready.
- mst_req_addr_o  out  ADDR_W  DBB read request address.
- mst_req_len_o  out  LEN_W  DBB read request length.
- mst_req_id_o  out  ID_W  DBB read request ID, {channel index, local ID}.
- mst_rdat_valid_i  in  1  DBB read data valid.
- mst_rdat_ready_o  out  1  DBB read data ready.
- mst_rdat_data_i  in  DATA_W  DBB read data.
- mst_rdat_last_i  in  1  DBB read data last beat.
- mst_rdat_id_i  in  ID_W  DBB read data ID.
- idle_o  out  1  no request pending and all outstanding counters zero.
- err_o  out  1  sticky: read data carried an invalid channel index.
- stall_cnt_o  out  N_CH*32  per-channel stall counters (optional feature).

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - Output register empty: mst_req_valid_o=0; addr, len and ID outputs =0.
  - Round-robin pointer =0.
  - All outstanding counters =0.
  - err_o=0, idle_o=1, stall counters =0.
- Output-register FSM, states ARB_IDLE and ARB_HOLD:
  - ARB_IDLE: if at least one channel is eligible, grant one, load the request into the register, assert ch_req_ready_o[g] for that same cycle, then go to ARB_HOLD.
  - ARB_HOLD: mst_req_valid_o=1 with stable fields. On mst_req_ready_i, either reload from a new grant in that same cycle (stay in ARB_HOLD) or, if no channel is eligible, go to ARB_IDLE.
  - Request latency: 1 cycle from channel handshake to mst_req_valid_o. Full throughput is 1 request/cycle.
- Eligibility: ch_req_valid_i[c] high and outst[c] < MAX_OUTST.
- Round-robin: search starts at the pointer; after a grant to channel g, pointer = (g+1) mod N_CH. At most one ch_req_ready_o bit is high per cycle.
- Outstanding counter outst[c]:
  - +1 on a DBB request handshake carrying channel c.
  - -1 on a read data handshake with last=1 and channel index c.
  - Both in the same cycle: unchanged.
  - Never wraps; by design it cannot exceed MAX_OUTST.
- Read data routing is combinational; the channel index is c = mst_rdat_id_i[ID_W-1 -: CH_W].
  - ch_rdat_valid_o[c] = mst_rdat_valid_i; all other channels see 0.
  - mst_rdat_ready_o = ch_rdat_ready_i[c].
  - Data, last and local ID are broadcast to all channels.
- Invalid channel index (c >= N_CH, possible when N_CH is not a power of 2): the beat is accepted (mst_rdat_ready_o=1), dropped, and err_o is set until reset.
- idle_o = FSM in ARB_IDLE and all outst==0; registered, so it lags by 1 cycle.
- The arbiter never reorders data; beat order is the DBB order.

Optional Feature:
- Macro NVDLA_DBB_ARB_PERF_EN.
- Defined:
  - stall_cnt_o[c] counts cycles with ch_req_valid_i[c]=1 and ch_req_ready_o[c]=0.
  - Counters saturate at 0xFFFFFFFF and clear only on reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- nvdla_package gains:
  - enum state_arb_fsm_t {ARB_IDLE, ARB_HOLD};
  - constant NVDLA_DBB_MAX_CH=16;
  - a function clog2_min1 (CH_W=1 when N_CH=2).
- Sub-module nvdla_rr_arbiter (N_CH): inputs eligible vector, pointer and enable; outputs one-hot grant, grant index and grant-valid; purely combinational search.

Test Plan:
- Reset with all 4 channels valid, MAX_OUTST=8, mst_req_ready_i=1 -> grants ch0,1,2,3,0..., one per cycle; IDs 0x00,0x40,0x80,0xC0 for local ID 0.
- Hold mst_req_ready_i=0 for 5 cycles with ch1 valid (addr 0x1000, len 3) -> mst_req_* stable for 5 cycles; ch_req_ready_o=0 after the first grant until release.
- ch2 issues 8 bursts with no data returned -> 9th request stalls (ch_req_ready_o[2]=0); one last beat for ch2 -> outst drops to 7 and the next request is granted within 1 cycle.
- Read data ID 0x81, 4 beats, ch_rdat_ready_i[2] toggling -> only ch_rdat_valid_o[2] is asserted; mst_rdat_ready_o follows ready; local ID 0x01 on the last beat.
- N_CH=3, read data arriving with ID 0xC0 -> beat accepted in 1 cycle, err_o=1 and sticky; no channel valid.
- NVDLA_DBB_ARB_PERF_EN, ch3 valid for 10 cycles while ch0..2 are granted -> stall_cnt_o[3]=non-zero exact count matching the ungranted cycles; with the macro undefined -> stall_cnt_o=0.
